// File: rtl/pin_loopback_tester.sv
// pin_loopback_tester: walking-pattern pad driver/checker that flags stuck, open and shorted pins
module pin_loopback_tester #(
  parameter int N_PINS = 40,
  parameter int SETTLE_CYCLES = 16,
  parameter int PIN_W = $clog2(N_PINS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        mode,
  input  logic [N_PINS-1:0] pin_in,
  output logic [N_PINS-1:0] pin_out,
  output logic [N_PINS-1:0] pin_oe,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [N_PINS-1:0] fail_mask,
  output logic              first_fail_valid,
  output logic [PIN_W-1:0]  first_fail_pin,
  output logic [PIN_W-1:0]  cur_pin
);
  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;
  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
  state_t state, state_n;
  logic [N_PINS-1:0] sync1, sync2, onehot, mismatch;
  logic [CNT_W-1:0] cnt;
  logic [PIN_W-1:0] step, low_pin;
  logic both, walk_zero, active, last_step, go, stop;
  assign active = state == SETTLE || state == SAMPLE;
  assign onehot = {{(N_PINS-1){1'b0}}, 1'b1} << step;
  assign pin_out = active ? (walk_zero ? ~onehot : onehot) : '0;
  assign pin_oe = {N_PINS{active}};
  assign busy = active;
  assign done = state == DONE;
  assign pass = done && ~|fail_mask;
  assign cur_pin = active ? step : '0;
  assign mismatch = sync2 ^ pin_out;
  assign last_step = step == PIN_W'(N_PINS - 1);
  assign stop = abort && state != IDLE;
  assign go = start && !abort && !active;
  // pads are asynchronous; only the second flop is ever compared
  always_ff @(posedge clk) begin
    sync1 <= rst_n ? pin_in : '0;
    sync2 <= rst_n ? sync1 : '0;
  end
  // lowest-index mismatching pin for first-fail capture
  always_comb begin
    low_pin = '0;
    for (int i = N_PINS - 1; i >= 0; i--)
      if (mismatch[i]) low_pin = PIN_W'(i);
  end
  // next-state: abort beats start, start is accepted from IDLE or DONE
  always_comb begin
    state_n = state;
    if (stop) state_n = IDLE;
    else if (go) state_n = SETTLE;
    else if (state == SETTLE && cnt == '0) state_n = SAMPLE;
    else if (state == SAMPLE) state_n = (!last_step || (both && !walk_zero)) ? SETTLE : DONE;
  end
  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  end
  // step/settle bookkeeping and result accumulation; abort leaves results untouched
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      both <= 1'b0;
      walk_zero <= 1'b0;
      step <= '0;
      cnt <= '0;
      fail_mask <= '0;
      first_fail_valid <= 1'b0;
      first_fail_pin <= '0;
    end else if (go) begin
      both <= mode[1];
      walk_zero <= mode == 2'b01;
      step <= '0;
      cnt <= CNT_W'(SETTLE_CYCLES - 1);
      fail_mask <= '0;
      first_fail_valid <= 1'b0;
      first_fail_pin <= '0;
    end else if (!stop) begin
      if (state == SETTLE) cnt <= cnt - CNT_W'(1);
      if (state == SAMPLE) begin
        fail_mask <= fail_mask | mismatch;
        if (|mismatch && !first_fail_valid) begin
          first_fail_valid <= 1'b1;
          first_fail_pin <= low_pin;
        end
        cnt <= CNT_W'(SETTLE_CYCLES - 1);
        step <= last_step ? '0 : step + PIN_W'(1);
        if (last_step) walk_zero <= 1'b1;
      end
    end
  end
endmodule
